// File: rtl/rx_pkg.sv
// Shared types and defaults for the RX integrate-and-dump path.
package rx_pkg;

  localparam int RX_SAMPLE_W       = 16;
  localparam int RX_DECIM_LOG2_DEF = 2;

  typedef logic signed [RX_SAMPLE_W-1:0] rx_sample_t;

  typedef struct packed {
    rx_sample_t re;
    rx_sample_t im;
  } rx_iq_t;

endpackage

// File: rtl/rx_accum_lane.sv
// Single-rail accumulator with dump-time divide by 2^DECIM_LOG2.
// RX_ROUND_EN selects round-half-up instead of floor at the dump.
module rx_accum_lane #(
  parameter int W          = 16,
  parameter int DECIM_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] sample_i,
  input  logic                clear_i,
  input  logic                valid_i,
  input  logic                dump_i,
  output logic signed [W-1:0] out_o
);

  localparam int AW = W + DECIM_LOG2;

`ifdef RX_ROUND_EN
  // Half an LSB of the output; zero when DECIM_LOG2 is 0 so pass-through is exact.
  localparam logic signed [AW:0] RND_INC = (AW+1)'((1 << DECIM_LOG2) >> 1);
`else
  localparam logic signed [AW:0] RND_INC = '0;
`endif

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] sum_raw;
  logic signed [AW:0]   sum_rnd;
  logic signed [W-1:0]  out_q, out_d;

  always_comb begin
    sum_raw = acc_q + AW'(sample_i);
    sum_rnd = (AW+1)'(sum_raw) + RND_INC;
    acc_d   = acc_q;
    out_d   = out_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (valid_i) begin
      if (dump_i) begin
        acc_d = '0;
        out_d = W'(sum_rnd >>> DECIM_LOG2);
      end else begin
        acc_d = sum_raw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/rx_iq_accum_dump.sv
// Integrate-and-dump I/Q decimator: averages 2^DECIM_LOG2 valid samples per output.
// Optional macro RX_ROUND_EN switches the dump from floor to round-half-up.
module rx_iq_accum_dump
  import rx_pkg::*;
#(
  parameter int W          = RX_SAMPLE_W,
  parameter int DECIM_LOG2 = RX_DECIM_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] iredata,
  input  logic signed [W-1:0] iimdata,
  input  logic                ivalid,
  input  logic                iclear,
  output logic signed [W-1:0] oredata,
  output logic signed [W-1:0] oimdata,
  output logic                ovalid,
  output logic [((DECIM_LOG2 > 0) ? DECIM_LOG2 : 1)-1:0] ophase
);

  localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << DECIM_LOG2) - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovalid_q, ovalid_d;
  logic          dump;

  // With DECIM_LOG2 = 0, LAST is 0 so every valid sample dumps and cnt stays 0.
  assign dump = (cnt_q == LAST);

  always_comb begin
    cnt_d    = cnt_q;
    ovalid_d = 1'b0;
    if (iclear) begin
      cnt_d = '0;
    end else if (ivalid) begin
      cnt_d    = dump ? '0 : CW'(cnt_q + 1'b1);
      ovalid_d = dump;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ovalid_q <= ovalid_d;
    end
  end

  rx_accum_lane #(.W(W), .DECIM_LOG2(DECIM_LOG2)) u_lane_re (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_i (iredata),
    .clear_i  (iclear),
    .valid_i  (ivalid),
    .dump_i   (dump),
    .out_o    (oredata)
  );

  rx_accum_lane #(.W(W), .DECIM_LOG2(DECIM_LOG2)) u_lane_im (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_i (iimdata),
    .clear_i  (iclear),
    .valid_i  (ivalid),
    .dump_i   (dump),
    .out_o    (oimdata)
  );

  assign ovalid = ovalid_q;
  assign ophase = cnt_q;

endmodule

// File: tb/tb_rx_iq_accum_dump.sv
// Directed bench for rx_iq_accum_dump: DECIM_LOG2=2 main instance plus a DECIM_LOG2=0 pass-through instance.
module tb_rx_iq_accum_dump;
  import rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  rx_sample_t  ire, iim;
  logic        iv, ic;

  rx_sample_t  o2re, o2im;
  logic        o2v;
  logic [1:0]  o2ph;
  rx_sample_t  o0re, o0im;
  logic        o0v;
  logic [0:0]  o0ph;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_iq_accum_dump #(.W(16), .DECIM_LOG2(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .iredata(ire), .iimdata(iim), .ivalid(iv), .iclear(ic),
    .oredata(o2re), .oimdata(o2im), .ovalid(o2v), .ophase(o2ph)
  );

  rx_iq_accum_dump #(.W(16), .DECIM_LOG2(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .iredata(ire), .iimdata(iim), .ivalid(iv), .iclear(ic),
    .oredata(o0re), .oimdata(o0im), .ovalid(o0v), .ophase(o0ph)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int re, input int im, input logic v, input logic c);
    ire = 16'(re);
    iim = 16'(im);
    iv  = v;
    ic  = c;
    @(posedge clk);
    #1;
    $display("step re=%0d im=%0d v=%0b c=%0b -> ore=%0d oim=%0d ov=%0b ph=%0d",
             re, im, v, c, o2re, o2im, o2v, o2ph);
  endtask

  task automatic check_out(input string tag, input int re, input int im);
    check({tag, "_valid"}, int'(o2v), 1);
    check({tag, "_re"}, int'(o2re), re);
    check({tag, "_im"}, int'(o2im), im);
  endtask

  initial begin
    int exp_re, exp_im, r, q;
    rst_n = 1'b0;
    ire = '0; iim = '0; iv = 1'b0; ic = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_re", int'(o2re), 0);
    check("rst_im", int'(o2im), 0);
    check("rst_valid", int'(o2v), 0);
    check("rst_phase", int'(o2ph), 0);
    rst_n = 1'b1;

    // Partial block, then asynchronous reset mid-block discards it.
    step(7, 7, 1'b1, 1'b0);
    step(7, 7, 1'b1, 1'b0);
    check("partial_phase", int'(o2ph), 2);
    rst_n = 1'b0;
    #1;
    check("async_rst_phase", int'(o2ph), 0);
    check("async_rst_re", int'(o2re), 0);
    rst_n = 1'b1;
    step(0, 0, 1'b0, 1'b0);
    check("idle_valid", int'(o2v), 0);
    step(10, 20, 1'b1, 1'b0);
    step(10, 20, 1'b1, 1'b0);
    step(10, 20, 1'b1, 1'b0);
    check("fresh3_valid", int'(o2v), 0);
    step(10, 20, 1'b1, 1'b0);
    check_out("fresh4", 10, 20);

    // Constant input: two dumps over eight back-to-back samples.
    for (int i = 1; i <= 8; i++) begin
      step(100, -100, 1'b1, 1'b0);
      if (i == 4 || i == 8) check_out("const_dump", 100, -100);
      else check("const_novalid", int'(o2v), 0);
    end
    step(0, 0, 1'b0, 1'b0);
    check("const_single_pulse", int'(o2v), 0);

    // Floor vs round: I sum 3, Q sum -1.
`ifdef RX_ROUND_EN
    exp_re = 1; exp_im = 0;
`else
    exp_re = 0; exp_im = -1;
`endif
    step(1, -1, 1'b1, 1'b0);
    step(1, 0, 1'b1, 1'b0);
    step(1, 0, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b0);
    check_out("floor_round", exp_re, exp_im);

    // Extremes: same result with or without rounding.
    for (int i = 0; i < 4; i++) step(32767, -32768, 1'b1, 1'b0);
    check_out("extreme", 32767, -32768);

    // Gapped samples, idle cycles, then iclear with a concurrent sample.
    step(50, 50, 1'b1, 1'b0);
    step(50, 50, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0);
    check("gap_phase_hold", int'(o2ph), 2);
    step(500, 500, 1'b1, 1'b1);
    check("clear_phase", int'(o2ph), 0);
    check("clear_valid", int'(o2v), 0);
    check("clear_hold_re", int'(o2re), 32767);
    check("clear_hold_im", int'(o2im), -32768);
    for (int i = 1; i <= 4; i++) begin
      step(8, 8, 1'b1, 1'b0);
      if (i < 4) check("after_clear_novalid", int'(o2v), 0);
    end
    check_out("after_clear", 8, 8);
    step(0, 0, 1'b0, 1'b0);
    check("after_clear_pulse_end", int'(o2v), 0);

    // DECIM_LOG2=0 instance: registered pass-through.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(0, 65535)) - 32768;
      q = int'($urandom_range(0, 65535)) - 32768;
      step(r, q, 1'b1, 1'b0);
      check("pass_valid", int'(o0v), 1);
      check("pass_re", int'(o0re), r);
      check("pass_im", int'(o0im), q);
      check("pass_phase", int'(o0ph), 0);
    end
    step(0, 0, 1'b0, 1'b0);
    check("pass_idle_valid", int'(o0v), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_iq_accum_dump.md
Name: rx_iq_accum_dump

Overview:
- Downstream consumer of the loopback switch outputs, oredata_rx and oimdata_rx.
- Integrate-and-dump decimator for the RX complex baseband stream.
- Sums 2^DECIM_LOG2 consecutive valid I/Q samples, divides by the block length with an arithmetic shift, and emits one averaged I/Q pair with a single-cycle valid strobe.
- Feeds the RX demodulator at the reduced symbol-domain rate.

Parameters:
- W, 16, width of input/output I and Q samples (two's complement).
- DECIM_LOG2, 2, log2 of the decimation factor (DECIM = 2^DECIM_LOG2); legal range 0..6.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- iredata  input  W  I sample from the loopback switch (oredata_rx), signed.
- iimdata  input  W  Q sample from the loopback switch (oimdata_rx), signed.
- ivalid  input  1  sample strobe; iredata/iimdata are valid when high.
- iclear  input  1  synchronous restart of the current integration block.
- oredata  output  W  averaged I, signed, registered.
- oimdata  output  W  averaged Q, signed, registered.
- ovalid  output  1  one-cycle strobe; oredata/oimdata are updated in the same cycle.
- ophase  output  DECIM_LOG2 (min 1)  current sample index within the block, equal to cnt.

Behaviour:
- Reset (rst_n=0, asynchronous) clears:
  - accumulators acc_re and acc_im (width W+DECIM_LOG2, signed);
  - counter cnt;
  - oredata, oimdata and ovalid, all to 0.
- Priority: iclear > ivalid.
- When iclear=1 at an edge:
  - acc_re/acc_im clear to 0, cnt clears to 0, ovalid drives 0;
  - a concurrent ivalid sample is discarded;
  - oredata/oimdata hold their last values.
- ivalid=1 with cnt < DECIM-1: acc += sign-extended sample (I and Q independently), then cnt++. ovalid=0.
- ivalid=1 with cnt == DECIM-1 (dump):
  - sum = acc + sample;
  - oredata/oimdata = sum >>> DECIM_LOG2 (arithmetic shift, i.e. floor);
  - ovalid=1 on the following edge (latency 1 cycle from the last sample);
  - acc loads 0 (not the sample) and cnt wraps to 0.
- ivalid=0: acc and cnt hold; ovalid=0.
- ovalid is high for exactly one cycle per dump, never two consecutive cycles unless DECIM=1 and ivalid stays high.
- DECIM_LOG2=0: registered pass-through.
  - Every valid sample is output one cycle later with ovalid=1.
  - cnt is constant 0 and ophase is 1 bit, tied to 0.
- Width rule: accumulator width W+DECIM_LOG2 guarantees no overflow for any input. The shifted result always fits in W bits, so no saturation is needed.
- Back-to-back ivalid with no gaps gives a sustained output rate of exactly 1 per DECIM samples.
- Reset asserted mid-block discards the partial sum. After release, the block starts at cnt=0.

Optional Feature:
- Macro: RX_ROUND_EN.
- Defined: for DECIM_LOG2>0, the dump computes (sum + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2, i.e. round half toward +inf.
  - The result provably still fits in W bits; max positive case: (4*32767+2)>>2 = 32767.
- Undefined: truncation (floor) as described in Behaviour.
- Either way, DECIM_LOG2=0 is unaffected.

Decomposition:
- Shared package rx_pkg holds:
  - RX_SAMPLE_W = 16;
  - a signed W-bit sample typedef;
  - an I/Q pair struct typedef (re, im);
  - the default DECIM_LOG2.
- One sub-module is natural: rx_accum_lane, a single-rail accumulator + shift/round. Instantiate it twice (I and Q), sharing cnt and the control from the top.

Test Plan:
- Reset/idle: rst_n=0 mid-block, then release and idle -> oredata=oimdata=0, ovalid=0, ophase=0; after release the first output needs 4 fresh samples.
- Constant input, DECIM_LOG2=2: I=100, Q=-100 continuous for 8 samples -> two ovalid pulses, 1 cycle after samples 4 and 8, each with I=100, Q=-100.
- Floor vs round: I samples 1,1,1,0 (sum 3):
  - without RX_ROUND_EN -> I=0;
  - with RX_ROUND_EN -> I=1.
  - Q samples -1,0,0,0 -> Q=-1 without rounding, Q=0 with rounding.
- Extremes: four samples of 32767 -> 32767; four samples of -32768 -> -32768; identical result with rounding enabled.
- Gapped ivalid plus iclear: 2 samples, 3 idle cycles, then iclear concurrent with a sample of 500, then four samples of 8 -> single ovalid with I=8 (partial sum and the cleared sample discarded).
- DECIM_LOG2=0: random samples with ivalid every cycle -> outputs equal the inputs delayed by 1 cycle, ovalid continuously high.
